// File: rtl/vga_pkg.sv
// Shared timing constants and colour type for the VGA text driver.
// 640x480@60 Hz raster with 8x16 character cells on an 80x30 grid.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int CELL_W = 8;
  localparam int CELL_H = 16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

endpackage

// File: rtl/vga_text_driver_if.sv
// Character-buffer read bus plus VGA pins.
// master = the driver, slave = the buffer/monitor side.
interface vga_text_driver_if;

  logic [6:0]  read_hchar;
  logic [4:0]  read_vchar;
  logic [2:0]  read_hoffset;
  logic [3:0]  read_voffset;
  logic        read_lit;
  logic        out_of_bounds;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [11:0] vga_rgb;
  logic        frame_tick;

  modport master (
    output read_hchar,
    output read_vchar,
    output read_hoffset,
    output read_voffset,
    input  read_lit,
    input  out_of_bounds,
    output vga_hsync,
    output vga_vsync,
    output vga_rgb,
    output frame_tick
  );

  modport slave (
    input  read_hchar,
    input  read_vchar,
    input  read_hoffset,
    input  read_voffset,
    output read_lit,
    output out_of_bounds,
    input  vga_hsync,
    input  vga_vsync,
    input  vga_rgb,
    input  frame_tick
  );

endinterface

// File: rtl/vga_timing.sv
// Raster counters, stage-0 blanking/sync decode and frame tick.
// Address slices come straight off the counter flops.
module vga_timing
  import vga_pkg::*;
#(
  parameter int p_h_visible = H_VISIBLE,
  parameter int p_h_front   = H_FRONT,
  parameter int p_h_sync    = H_SYNC,
  parameter int p_h_back    = H_BACK,
  parameter int p_v_visible = V_VISIBLE,
  parameter int p_v_front   = V_FRONT,
  parameter int p_v_sync    = V_SYNC,
  parameter int p_v_back    = V_BACK
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [6:0] hchar_o,
  output logic [4:0] vchar_o,
  output logic [2:0] hoffset_o,
  output logic [3:0] voffset_o,
  output logic       active0_o,
  output logic       hs0_o,
  output logic       vs0_o,
  output logic       frame_tick_o
);

  localparam int H_SUM =
    p_h_visible + p_h_front + p_h_sync + p_h_back;
  localparam int V_SUM =
    p_v_visible + p_v_front + p_v_sync + p_v_back;

  if (H_SUM > 1023 || V_SUM > 1023) begin : g_bad_sum
    $error("vga_timing: timing sum exceeds 10 bits");
  end

  localparam logic [9:0] H_VIS  = 10'(p_h_visible);
  localparam logic [9:0] HS_LO  =
    10'(p_h_visible + p_h_front);
  localparam logic [9:0] HS_HI  =
    10'(p_h_visible + p_h_front + p_h_sync);
  localparam logic [9:0] H_LAST = 10'(H_SUM - 1);

  localparam logic [9:0] V_VIS  = 10'(p_v_visible);
  localparam logic [9:0] VS_LO  =
    10'(p_v_visible + p_v_front);
  localparam logic [9:0] VS_HI  =
    10'(p_v_visible + p_v_front + p_v_sync);
  localparam logic [9:0] V_LAST = 10'(V_SUM - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       frame_tick_q, frame_tick_d;

  // Next raster position and frame-start detect.
  always_comb begin
    h_cnt_d      = h_cnt_q + 10'd1;
    v_cnt_d      = v_cnt_q;
    frame_tick_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) v_cnt_d = '0;
      else                   v_cnt_d = v_cnt_q + 10'd1;
    end
  end

  // Counter and frame-tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign hchar_o   = h_cnt_q[9:3];
  assign hoffset_o = h_cnt_q[2:0];
  assign vchar_o   = v_cnt_q[8:4];
  assign voffset_o = v_cnt_q[3:0];

  assign active0_o = (h_cnt_q < H_VIS) &&
                     (v_cnt_q < V_VIS);
  assign hs0_o = !((h_cnt_q >= HS_LO) &&
                   (h_cnt_q <  HS_HI));
  assign vs0_o = !((v_cnt_q >= VS_LO) &&
                   (v_cnt_q <  VS_HI));

  assign frame_tick_o = frame_tick_q;

endmodule

// File: rtl/vga_text_driver.sv
// VGA text driver: raster timing, buffer addressing and a
// two-stage sync/colour pipeline matching the buffer read latency.
module vga_text_driver
  import vga_pkg::*;
#(
  parameter int          p_h_visible  = H_VISIBLE,
  parameter int          p_h_front    = H_FRONT,
  parameter int          p_h_sync     = H_SYNC,
  parameter int          p_h_back     = H_BACK,
  parameter int          p_v_visible  = V_VISIBLE,
  parameter int          p_v_front    = V_FRONT,
  parameter int          p_v_sync     = V_SYNC,
  parameter int          p_v_back     = V_BACK,
  parameter logic [11:0] p_fg_rgb     = 12'hFFF,
  parameter logic [11:0] p_bg_rgb     = 12'h000,
  parameter logic [11:0] p_border_rgb = 12'h008
) (
  input logic                clk,
  input logic                rst_n,
  vga_text_driver_if.master  bus
);

  logic active0, hs0, vs0;
  logic frame_tick;

  vga_timing #(
    .p_h_visible (p_h_visible),
    .p_h_front   (p_h_front),
    .p_h_sync    (p_h_sync),
    .p_h_back    (p_h_back),
    .p_v_visible (p_v_visible),
    .p_v_front   (p_v_front),
    .p_v_sync    (p_v_sync),
    .p_v_back    (p_v_back)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .hchar_o      (bus.read_hchar),
    .vchar_o      (bus.read_vchar),
    .hoffset_o    (bus.read_hoffset),
    .voffset_o    (bus.read_voffset),
    .active0_o    (active0),
    .hs0_o        (hs0),
    .vs0_o        (vs0),
    .frame_tick_o (frame_tick)
  );

  logic   active1_q, active1_d;
  logic   hs1_q, hs1_d;
  logic   vs1_q, vs1_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  rgb12_t rgb_q, rgb_d;

  // Stage-1 capture and stage-2 colour select (border beats lit).
  always_comb begin
    active1_d = active0;
    hs1_d     = hs0;
    vs1_d     = vs0;
    hsync_d   = hs1_q;
    vsync_d   = vs1_q;
    rgb_d     = '0;
    if (active1_q) begin
      if (bus.out_of_bounds)  rgb_d = rgb12_t'(p_border_rgb);
      else if (bus.read_lit)  rgb_d = rgb12_t'(p_fg_rgb);
      else                    rgb_d = rgb12_t'(p_bg_rgb);
    end
  end

  // Pipeline registers; sync idles high so reset never glitches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active1_q <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      rgb_q     <= '0;
    end else begin
      active1_q <= active1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      rgb_q     <= rgb_d;
    end
  end

  assign bus.vga_hsync  = hsync_q;
  assign bus.vga_vsync  = vsync_q;
  assign bus.vga_rgb    = rgb_q;
  assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_vga_text_driver.sv
// Directed bench for vga_text_driver: line timing, colour mux,
// addressing, async reset, plus a shrunken raster for frame timing.
module tb_vga_text_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   mode  = 0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  int   hs_n, hs_first, bticks;
  int   vs_n, vs_first;
  int   sticks[$];

  always #5 clk = ~clk;

  vga_text_driver_if bus ();
  vga_text_driver_if sbus ();

  vga_text_driver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vga_text_driver #(
    .p_h_visible (16),
    .p_h_front   (2),
    .p_h_sync    (4),
    .p_h_back    (2),
    .p_v_visible (8),
    .p_v_front   (2),
    .p_v_sync    (2),
    .p_v_back    (3)
  ) sdut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  // Buffer model: one-cycle registered response.
  always @(posedge clk) begin
    if (mode == 0) begin
      bus.read_lit      <= bus.read_hoffset[0];
      bus.out_of_bounds <= 1'b0;
    end else begin
      bus.read_lit      <= 1'b1;
      bus.out_of_bounds <= (bus.read_hchar >= 7'd32);
    end
    sbus.read_lit      <= 1'b0;
    sbus.out_of_bounds <= 1'b0;
  end

  typedef struct {
    int          cyc;
    int          mode;
    logic        hs;
    logic [11:0] rgb;
    logic        tick;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic clr();
    cyc = 0; hs_n = 0; hs_first = -1; bticks = 0;
    vs_n = 0; vs_first = -1;
    sticks.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc <= 800 && !bus.vga_hsync) begin
      if (hs_n == 0) hs_first = cyc;
      hs_n++;
    end
    if (bus.frame_tick) bticks++;
    if (!sbus.vga_vsync) begin
      if (vs_n == 0) vs_first = cyc;
      vs_n++;
    end
    if (sbus.frame_tick) sticks.push_back(cyc);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_hsync"}, int'(bus.vga_hsync), 1);
    chk({tag, "_vsync"}, int'(bus.vga_vsync), 1);
    chk({tag, "_rgb"}, int'(bus.vga_rgb), 0);
    chk({tag, "_tick"}, int'(bus.frame_tick), 0);
    chk({tag, "_hchar"}, int'(bus.read_hchar), 0);
    chk({tag, "_vchar"}, int'(bus.read_vchar), 0);
    chk({tag, "_hoff"}, int'(bus.read_hoffset), 0);
    chk({tag, "_voff"}, int'(bus.read_voffset), 0);
  endtask

  initial begin
    // line 0: lit = hoffset[0]; line 1: border for hchar>=32
    tbl.push_back('{1,    0, 1'b1, 12'h000, 1'b1});
    tbl.push_back('{2,    0, 1'b1, 12'h000, 1'b0});
    tbl.push_back('{3,    0, 1'b1, 12'hFFF, 1'b0});
    tbl.push_back('{4,    0, 1'b1, 12'h000, 1'b0});
    tbl.push_back('{641,  0, 1'b1, 12'hFFF, 1'b0});
    tbl.push_back('{642,  0, 1'b1, 12'h000, 1'b0});
    tbl.push_back('{657,  0, 1'b1, 12'h000, 1'b0});
    tbl.push_back('{658,  0, 1'b0, 12'h000, 1'b0});
    tbl.push_back('{753,  0, 1'b0, 12'h000, 1'b0});
    tbl.push_back('{754,  0, 1'b1, 12'h000, 1'b0});
    tbl.push_back('{800,  0, 1'b1, 12'h000, 1'b0});
    tbl.push_back('{802,  1, 1'b1, 12'hFFF, 1'b0});
    tbl.push_back('{1057, 1, 1'b1, 12'hFFF, 1'b0});
    tbl.push_back('{1058, 1, 1'b1, 12'h008, 1'b0});
    tbl.push_back('{1441, 1, 1'b1, 12'h008, 1'b0});
    tbl.push_back('{1442, 1, 1'b1, 12'h000, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst0");

    @(negedge clk);
    rst_n = 1'b1;
    clr();

    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      while (cyc < tbl[i].cyc) step();
      chk($sformatf("hs@%0d", cyc),
          int'(bus.vga_hsync), int'(tbl[i].hs));
      chk($sformatf("rgb@%0d", cyc),
          int'(bus.vga_rgb), int'(tbl[i].rgb));
      chk($sformatf("tick@%0d", cyc),
          int'(bus.frame_tick), int'(tbl[i].tick));
    end
    chk("hs_first", hs_first, 658);
    chk("hs_width", hs_n, 96);

    // h=645, v=37 is blanking but addresses keep slicing
    while (cyc < 30245) step();
    chk("addr_hchar", int'(bus.read_hchar), 80);
    chk("addr_hoff", int'(bus.read_hoffset), 5);
    chk("addr_vchar", int'(bus.read_vchar), 2);
    chk("addr_voff", int'(bus.read_voffset), 5);
    chk("addr_vsync", int'(bus.vga_vsync), 1);
    step();
    step();
    chk("addr_rgb_blank", int'(bus.vga_rgb), 0);
    chk("tick_count", bticks, 1);

    // mid-line async reset at h=300 of line 38
    while (cyc < 30700) step();
    chk("pre_rst_hoff", int'(bus.read_hoffset), 4);
    chk("pre_rst_rgb", int'(bus.vga_rgb), 12'h008);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst1");
    @(negedge clk);
    mode = 0;
    rst_n = 1'b1;
    clr();

    repeat (800) step();
    chk("rst_hs_first", hs_first, 658);
    chk("rst_hs_width", hs_n, 96);
    chk("rst_tick_count", bticks, 1);

    // small raster: 24 clocks/line, 15 lines/frame = 360
    chk("s_vs_first", vs_first, 242);
    chk("s_vs_lows", vs_n, 96);
    chk("s_tick_n", sticks.size(), 3);
    if (sticks.size() == 3) begin
      chk("s_tick0", sticks[0], 1);
      chk("s_tick1", sticks[1], 361);
      chk("s_tick2", sticks[2], 721);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
